rng_sampler: RTL and testbench

- Consumer end of the 12-bit rng interface.
- Drives the rng's seed-load strobe after reset, then serves on-demand requests for a uniform random value in [0, limit) using the rng's free-running output.
- Sits between the rng instance and game/VGA logic, e.g. random sprite positions and colours.
- Uses masked rejection sampling with a bounded-retry fallback, so every request completes in bounded time.

---
 rtl/rng_sampler_pkg.sv | 17 +
 rtl/rng_mask_gen.sv | 23 ++
 rtl/rng_sampler.sv | 130 +++++++++++++
 tb/tb_rng_sampler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rng_sampler_pkg.sv
// Shared types and constants for the rng_sampler consumer block.
// Imported by the sampler top and its mask generator.
package rng_sampler_pkg;

  localparam int RNG_W_DEFAULT = 12;

  // Seed and try counters; wide enough for SEED_CYCLES and MAX_TRIES up to 15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_IDLE = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : rng_sampler_pkg

// File: rtl/rng_mask_gen.sv
// Combinational mask generator: smallest 2^k-1 covering lim-1.
// A limit of 0 wraps to lim-1 = all ones, i.e. the full sample range.
module rng_mask_gen #(
  parameter int RNG_W = 12
) (
  input  logic [RNG_W-1:0] lim_i,
  output logic [RNG_W-1:0] mask_o
);

  logic [RNG_W-1:0] dec;

  assign dec = lim_i - RNG_W'(1);

  // Bit i of the mask is set when any bit at or above i in lim-1 is set.
  // NOTE: every always_comb output is assigned before any conditional logic so no latch can be inferred.
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < RNG_W; i++) begin
      mask_o[i] = |(dec >> i);
    end
  end

endmodule : rng_mask_gen

// File: rtl/rng_sampler.sv
// Drives the rng seed-load strobe after reset, then returns uniform values in
// [0, limit) by masked rejection sampling with a bounded-retry fallback.
module rng_sampler
  import rng_sampler_pkg::*;
#(
  parameter int RNG_W       = RNG_W_DEFAULT,
  parameter int SEED_CYCLES = 2,
  parameter int MAX_TRIES   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RNG_W-1:0] rng_in,
  output logic             loadseed_o,
  input  logic             req_i,
  input  logic [RNG_W-1:0] limit_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [RNG_W-1:0] value_o,
  output logic             fallback_o
);

  state_t           state_q;
  logic [CNT_W-1:0] seed_cnt_q;
  logic [CNT_W-1:0] try_q;
  logic [RNG_W-1:0] lim_q;
  logic [RNG_W-1:0] mask_q;
  logic             loadseed_q;
  logic             ready_q;
  logic             valid_q;
  logic [RNG_W-1:0] value_q;
  logic             fallback_q;

  logic [RNG_W-1:0] mask_d;
  logic [RNG_W-1:0] samp_d;
  logic [RNG_W-1:0] fold_d;

  rng_mask_gen #(
    .RNG_W (RNG_W)
  ) u_mask_gen (
    .lim_i  (limit_i),
    .mask_o (mask_d)
  );

  assign samp_d = rng_in & mask_q;
  // Only used when samp_d >= lim_q; the mask bound keeps the result below lim_q.
  assign fold_d = samp_d - lim_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SEED;
      seed_cnt_q <= '0;
      try_q      <= '0;
      lim_q      <= '0;
      mask_q     <= '0;
      loadseed_q <= 1'b1;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      value_q    <= '0;
      fallback_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_SEED: begin
          if (seed_cnt_q == CNT_W'(SEED_CYCLES - 1)) begin
            state_q    <= ST_IDLE;
            loadseed_q <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            seed_cnt_q <= seed_cnt_q + CNT_W'(1);
          end
        end

        ST_IDLE: begin
          if (req_i) begin
            lim_q   <= limit_i;
            mask_q  <= mask_d;
            try_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_DRAW;
          end
        end

        ST_DRAW: begin
          if (lim_q == '0) begin
            value_q    <= rng_in;
            fallback_q <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else if (lim_q == RNG_W'(1)) begin
            value_q    <= '0;
            fallback_q <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else if (samp_d < lim_q) begin
            value_q    <= samp_d;
            fallback_q <= 1'b0;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else if (try_q == CNT_W'(MAX_TRIES - 1)) begin
            value_q    <= fold_d;
            fallback_q <= 1'b1;
            valid_q    <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            try_q <= try_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q    <= ST_IDLE;
          loadseed_q <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign loadseed_o = loadseed_q;
  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign value_o    = value_q;
  assign fallback_o = fallback_q;

endmodule : rng_sampler

// File: tb/tb_rng_sampler.sv
// Scoreboard bench for rng_sampler: directed requests push expected results,
// a negedge monitor pops and compares whenever valid_o pulses.
module tb_rng_sampler;

  localparam int W = 12;

  logic         clock;
  logic         reset;
  logic [W-1:0] rng_in;
  logic         loadseed_o;
  logic         req_i;
  logic [W-1:0] limit_i;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] value_o;
  logic         fallback_o;

  typedef struct {
    logic [W-1:0] value;
    logic         fb;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [W-1:0] rng_seq[16];

  rng_sampler #(
    .RNG_W       (W),
    .SEED_CYCLES (2),
    .MAX_TRIES   (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rng_in     (rng_in),
    .loadseed_o (loadseed_o),
    .req_i      (req_i),
    .limit_i    (limit_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .value_o    (value_o),
    .fallback_o (fallback_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got value 0x%0h, expected no valid (t=%0t)", value_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("value", 32'(value_o), 32'(e.value));
        check("fallback", 32'(fallback_o), 32'(e.fb));
        check("latency_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_ready(input bit pulse_done);
    int t;
    t = 0;
    while (!ready_o && t < 40) begin
      @(negedge clock);
      req_i   = pulse_done && (t == 0);
      limit_i = 12'd3;
      t++;
    end
    req_i = 1'b0;
    check("ready_return", 32'(ready_o), 32'd1);
  endtask

  // Issue one request; rng_seq[0..draws-1] feeds successive draw edges.
  task automatic run_req(input logic [W-1:0] lim, input int draws,
                         input logic [W-1:0] exp_val, input logic exp_fb,
                         input bit pulse_draw, input bit pulse_done);
    exp_t e;
    @(negedge clock);
    req_i   = 1'b1;
    limit_i = lim;
    e.value = exp_val;
    e.fb    = exp_fb;
    e.due   = cyc + 1 + draws;
    sb.push_back(e);
    @(negedge clock);
    req_i   = 1'b0;
    limit_i = ~lim;
    rng_in  = rng_seq[0];
    for (int i = 1; i < draws; i++) begin
      @(negedge clock);
      rng_in  = rng_seq[i];
      req_i   = pulse_draw && (i == 1);
      limit_i = 12'd3;
    end
    wait_ready(pulse_done);
  endtask

  task automatic check_seed();
    check("rel_loadseed", 32'(loadseed_o), 32'd1);
    check("rel_ready", 32'(ready_o), 32'd0);
    check("rel_value", 32'(value_o), 32'd0);
    check("rel_fallback", 32'(fallback_o), 32'd0);
    check("rel_valid", 32'(valid_o), 32'd0);
    req_i = 1'b1;
    @(negedge clock);
    check("seed1_loadseed", 32'(loadseed_o), 32'd1);
    check("seed1_ready", 32'(ready_o), 32'd0);
    @(negedge clock);
    req_i = 1'b0;
    check("seed2_loadseed", 32'(loadseed_o), 32'd0);
    check("seed2_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_t e;
    reset   = 1'b1;
    req_i   = 1'b0;
    limit_i = '0;
    rng_in  = '0;
    repeat (3) @(negedge clock);
    check("rst_loadseed", 32'(loadseed_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    reset = 1'b0;
    check_seed();

    rng_seq[0] = 12'h003;
    run_req(12'd10, 1, 12'd3, 1'b0, 1'b0, 1'b1);

    rng_seq[0] = 12'h00E; rng_seq[1] = 12'h00C; rng_seq[2] = 12'h007;
    run_req(12'd10, 3, 12'd7, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) rng_seq[i] = 12'hFFF;
    run_req(12'd10, 8, 12'd5, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) rng_seq[i] = 12'h007;
    run_req(12'd5, 8, 12'd2, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) rng_seq[i] = 12'h01F;
    rng_seq[7] = 12'h010;
    run_req(12'd17, 8, 12'd16, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'hABC;
    run_req(12'd0, 1, 12'hABC, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'h5A5;
    run_req(12'd1, 1, 12'd0, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'h0C8;
    run_req(12'd100, 1, 12'd72, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'hFFF;
    run_req(12'h800, 1, 12'h7FF, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'hFFF; rng_seq[1] = 12'hFFE;
    run_req(12'hFFF, 2, 12'hFFE, 1'b0, 1'b0, 1'b0);

    rng_seq[0] = 12'h01F;
    run_req(12'd16, 1, 12'd15, 1'b0, 1'b0, 1'b0);

    // req_i held high: accepts land every third edge.
    @(negedge clock);
    base    = cyc;
    req_i   = 1'b1;
    limit_i = 12'd4;
    rng_in  = 12'h0A6;
    for (int k = 0; k < 3; k++) begin
      e.value = 12'd2;
      e.fb    = 1'b0;
      e.due   = base + 2 + 3 * k;
      sb.push_back(e);
    end
    repeat (9) @(negedge clock);
    req_i = 1'b0;
    check("held_req_ready", 32'(ready_o), 32'd1);
    check("held_req_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while retrying aborts the request.
    @(negedge clock);
    req_i   = 1'b1;
    limit_i = 12'd10;
    rng_in  = 12'hFFF;
    @(negedge clock);
    req_i = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_draw_ready", 32'(ready_o), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_loadseed", 32'(loadseed_o), 32'd1);
    check("abort_ready", 32'(ready_o), 32'd0);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_value", 32'(value_o), 32'd0);
    check("abort_fallback", 32'(fallback_o), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_seed();

    rng_seq[0] = 12'h009;
    run_req(12'd10, 1, 12'd9, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rng_sampler
